// File: rtl/dual_debounce.sv
// Two-channel synchroniser + debouncer producing clean levels a/b for the downstream FSM.
// Optional registered rising-edge pulses a_rise/b_rise are built only when DUAL_DEBOUNCE_RISE_EN is defined.
module dual_debounce #(
  parameter int CNT_W  = 20,
  parameter int STABLE = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] rise;

  assign raw = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= ZERO;
        cnt_q   <= '0;
      end else begin
        s1_q    <= raw[ch];
        s2_q    <= s1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // The counter is cleared on every WAIT exit, so it can never wrap.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ZERO: begin
          if (s2_q) begin
            state_d = WAIT1;
            cnt_d   = '0;
          end
        end
        WAIT1: begin
          if (!s2_q) begin
            state_d = ZERO;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = ONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ONE: begin
          if (!s2_q) begin
            state_d = WAIT0;
            cnt_d   = '0;
          end
        end
        WAIT0: begin
          if (s2_q) begin
            state_d = ONE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = ZERO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = '0;
        end
      endcase
    end

    assign lvl[ch] = (state_q == ONE) || (state_q == WAIT0);

`ifdef DUAL_DEBOUNCE_RISE_EN
    logic rise_q;

    // Only a committed 0->1 pulses; a WAIT0->ONE return is not a new edge.
    always_ff @(posedge clk) begin
      if (reset) rise_q <= 1'b0;
      else       rise_q <= (state_q == WAIT1) && (state_d == ONE);
    end

    assign rise[ch] = rise_q;
`else
    assign rise[ch] = 1'b0;
`endif
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign b_rise = rise[1];

endmodule

// File: tb/tb_dual_debounce.sv
// Scoreboard bench for dual_debounce with STABLE=4, CNT_W=3.
// Rise expectations are masked to 0 when DUAL_DEBOUNCE_RISE_EN is undefined.
module tb_dual_debounce;

`ifdef DUAL_DEBOUNCE_RISE_EN
  localparam logic RISE_EN = 1'b1;
`else
  localparam logic RISE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, a_rise, b_rise;

  dual_debounce #(.CNT_W(3), .STABLE(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .b_rise (b_rise)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    int         id;
    logic [3:0] exp;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    step   = 0;
  int    checks = 0;
  int    errors = 0;

  // Monitor: outputs are sampled 2 time units after each rising edge.
  initial begin
    item_t it;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        it  = sb.pop_front();
        act = {a, b, a_rise, b_rise};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL step%0d {a,b,a_rise,b_rise} got %b expected %b", it.id, act, it.exp);
        end
      end
    end
  end

  // Drive inputs seen by the next edge and queue the outputs expected just after it.
  task automatic st(input logic rs, input logic ra, input logic rb,
                    input logic ea, input logic eb, input logic ear, input logic ebr);
    item_t it;
    @(negedge clk);
    reset = rs;
    a_raw = ra;
    b_raw = rb;
    it.tgt = cyc + 1;
    it.id  = step;
    it.exp = {ea, eb, ear & RISE_EN, ebr & RISE_EN};
    sb.push_back(it);
    step++;
  endtask

  initial begin
    // Reset held 3 cycles with both raw inputs high.
    for (int i = 0; i < 3; i++) st(1, 1, 1, 0, 0, 0, 0);
    // Release: both channels commit on edge E0+6 with one rise pulse.
    for (int k = 0; k < 6; k++) st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 1, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) st(0, 1, 1, 1, 1, 0, 0);

    // a_raw low for 2 cycles: rejected, no pulse on the return to ONE.
    st(0, 0, 1, 1, 1, 0, 0);
    st(0, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) st(0, 1, 1, 1, 1, 0, 0);

    // a_raw low held from E0: a drops after E0+6.
    for (int k = 0; k < 6; k++) st(0, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) st(0, 0, 1, 0, 1, 0, 0);

    // a_raw high 3 cycles then low: bounce rejected.
    for (int k = 0; k < 3; k++) st(0, 1, 1, 0, 1, 0, 0);
    for (int k = 0; k < 9; k++) st(0, 0, 1, 0, 1, 0, 0);

    // Reset while b is in ONE clears it on that edge.
    st(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) st(0, 0, 0, 0, 0, 0, 0);

    // Both toggle on the same edge; b bounces once and commits 6 edges after its last change.
    st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 0, 0, 0, 0, 0);
    st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 1, 0, 0, 0, 0);
    st(0, 1, 1, 1, 0, 1, 0);
    st(0, 1, 1, 1, 0, 0, 0);
    st(0, 1, 1, 1, 0, 0, 0);
    st(0, 1, 1, 1, 1, 0, 1);
    st(0, 1, 1, 1, 1, 0, 0);

    // Bring both back to 0 via reset, then settle.
    st(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) st(0, 0, 0, 0, 0, 0, 0);

    // a enters WAIT1 and reaches cnt=2, then reset: a full delay is needed afterwards.
    for (int k = 0; k < 5; k++) st(0, 1, 0, 0, 0, 0, 0);
    st(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) st(0, 1, 0, 0, 0, 0, 0);
    st(0, 1, 0, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) st(0, 1, 0, 1, 0, 0, 0);

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      #3;
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending %0d expected 0", sb.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
